adder_driver: RTL

- Initiator for the adder operand/result interface: buffers operand pairs written by the host and drives them as `a_valid`/`a_data` and `b_valid`/`b_data`.
- Samples the returned `c_data` one cycle after each drive and stores every sum in a host-readable result buffer.
- Sits between the TSIM host register/memory shim and an adder-class accelerator.
- Used as the traffic generator for the accelerator and, with checking enabled, as its self-checking harness.

---
 rtl/adder_driver_if.sv | 20 ++
 rtl/adder_driver.sv | 138 +++++++++++++
 2 files changed

// File: rtl/adder_driver_if.sv
// Operand/result bus between adder_driver and an adder-class accelerator.
interface adder_driver_if #(
  parameter int ADDER_BITS = 8
);
  logic                  a_valid;
  logic [ADDER_BITS-1:0] a_data;
  logic                  b_valid;
  logic [ADDER_BITS-1:0] b_data;
  logic [ADDER_BITS-1:0] c_data;

  modport master (
    output a_valid, a_data, b_valid, b_data,
    input  c_data
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data,
    output c_data
  );
endinterface

// File: rtl/adder_driver.sv
// Buffers host operand pairs, drives them to an adder and stores the returned sums.
// Define ADDER_DRIVER_CHECK_EN to compare each sum and count mismatches per run.
module adder_driver #(
  parameter int ADDER_BITS = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_BITS  = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [ADDER_BITS-1:0] wr_a,
  input  logic [ADDER_BITS-1:0] wr_b,
  input  logic                  start,
  input  logic [ADDR_BITS:0]    len,
  output logic                  busy,
  output logic                  done,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [ADDER_BITS-1:0] rd_data,
  adder_driver_if.master        adder,
  output logic [ADDR_BITS:0]    mismatch_cnt,
  output logic                  error
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CAPTURE, S_DONE} state_t;

  localparam logic [ADDR_BITS:0]   DEPTH_L = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   LEN_ONE = 1;
  localparam logic [ADDR_BITS-1:0] IDX_ONE = 1;

  state_t                state;
  logic [ADDR_BITS-1:0]  idx;
  logic [ADDR_BITS-1:0]  idx_nx;
  logic [ADDR_BITS:0]    eff_len;
  logic [ADDR_BITS:0]    len_clamped;
  logic                  last_pair;
  logic                  host_wr;
  logic [ADDER_BITS-1:0] first_a;
  logic [ADDER_BITS-1:0] first_b;
  logic [ADDER_BITS-1:0] op_a   [DEPTH];
  logic [ADDER_BITS-1:0] op_b   [DEPTH];
  logic [ADDER_BITS-1:0] result [DEPTH];

  assign host_wr     = wr_en && (state == S_IDLE || state == S_DONE);
  assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
  assign idx_nx      = idx + IDX_ONE;
  assign last_pair   = ({1'b0, idx} == (eff_len - LEN_ONE));
  assign rd_data     = result[rd_addr];

  // A write to entry 0 alongside start must reach the first drive, so bypass the buffer.
  assign first_a = (host_wr && wr_addr == '0) ? wr_a : op_a[0];
  assign first_b = (host_wr && wr_addr == '0) ? wr_b : op_b[0];

  always_ff @(posedge clock) begin
    if (host_wr) begin
      op_a[wr_addr] <= wr_a;
      op_b[wr_addr] <= wr_b;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      eff_len       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      adder.a_valid <= 1'b0;
      adder.b_valid <= 1'b0;
      adder.a_data  <= '0;
      adder.b_data  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) result[i] <= '0;
    end else begin
      adder.a_valid <= 1'b0;
      adder.b_valid <= 1'b0;
      done          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            eff_len <= len_clamped;
            idx     <= '0;
            if (len_clamped == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state         <= S_DRIVE;
              busy          <= 1'b1;
              adder.a_valid <= 1'b1;
              adder.b_valid <= 1'b1;
              adder.a_data  <= first_a;
              adder.b_data  <= first_b;
            end
          end
        end
        S_DRIVE: state <= S_CAPTURE;
        S_CAPTURE: begin
          result[idx] <= adder.c_data;
          if (last_pair) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx           <= idx_nx;
            state         <= S_DRIVE;
            adder.a_valid <= 1'b1;
            adder.b_valid <= 1'b1;
            adder.a_data  <= op_a[idx_nx];
            adder.b_data  <= op_b[idx_nx];
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ADDER_DRIVER_CHECK_EN
  logic [ADDER_BITS-1:0] exp_sum;
  assign exp_sum = adder.a_data + adder.b_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mismatch_cnt <= '0;
      error        <= 1'b0;
    end else if (state == S_IDLE && start) begin
      mismatch_cnt <= '0;
      error        <= 1'b0;
    end else if (state == S_CAPTURE && adder.c_data != exp_sum) begin
      error <= 1'b1;
      if (mismatch_cnt != DEPTH_L) mismatch_cnt <= mismatch_cnt + LEN_ONE;
    end
  end
`else
  assign mismatch_cnt = '0;
  assign error        = 1'b0;
`endif

endmodule
